// File: rtl/ras_commit_tracker.sv
// Commit-side return address stack. On a flush it streams its entries to the fetch RAS (slot 0 = top).
// Optional feature macro: RAS_UNDERFLOW_CNT_EN (pop-on-empty event counter).
module ras_commit_tracker #(
  parameter int ENTRIES_NUM = 8,
  parameter int ADDR_W      = 32,
  localparam int IDX_W      = $clog2(ENTRIES_NUM),
  localparam int CNT_W      = IDX_W + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              commit_push_req,
  input  logic              commit_pop_req,
  input  logic [ADDR_W-1:0] commit_push_data,
  input  logic              flush_req,
  output logic              restore_valid,
  input  logic              restore_ready,
  output logic [IDX_W-1:0]  restore_idx,
  output logic [ADDR_W-1:0] restore_data,
  output logic              restore_entry_valid,
  output logic              restore_busy,
  output logic              restore_done,
  output logic [CNT_W-1:0]  depth,
  output logic [15:0]       underflow_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_DONE
  } state_e;

  logic [ADDR_W-1:0] mem_q [ENTRIES_NUM];
  logic [IDX_W-1:0]  tp_q, tp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  k_q, k_d;

  // Commit-side stack update
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    unique case ({commit_push_req, commit_pop_req})
      2'b10: begin
        tp_d   = tp_q + 1'b1;
        wr_en  = 1'b1;
        wr_idx = tp_q + 1'b1;
        if (cnt_q != CNT_W'(ENTRIES_NUM)) cnt_d = cnt_q + 1'b1;
      end
      2'b01: begin
        if (cnt_q != '0) begin
          tp_d  = tp_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      2'b11: begin
        // Call and return retire together: replace the top in place.
        wr_en  = 1'b1;
        wr_idx = tp_q;
        if (cnt_q == '0) cnt_d = CNT_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: the entry array has no reset; liveness comes from cnt_q, and invalid slots read as zero.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= commit_push_data;
  end

  // Restore sequencer
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_XFER;
          k_d     = '0;
        end
      end
      ST_XFER: begin
        if (flush_req) begin
          k_d = '0;
        end else if (restore_ready) begin
          if (k_q == IDX_W'(ENTRIES_NUM - 1)) begin
            state_d = ST_DONE;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = flush_req ? ST_XFER : ST_IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tp_q    <= '0;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      tp_q    <= tp_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  logic             in_xfer;
  logic             slot_live;
  logic [IDX_W-1:0] rd_idx;

  assign in_xfer   = (state_q == ST_XFER);
  assign slot_live = ({1'b0, k_q} < cnt_q);
  assign rd_idx    = tp_q - k_q;

  assign restore_valid       = in_xfer;
  assign restore_idx         = k_q;
  assign restore_entry_valid = in_xfer && slot_live;
  assign restore_data        = (in_xfer && slot_live) ? mem_q[rd_idx] : '0;
  assign restore_busy        = (state_q != ST_IDLE);
  assign restore_done        = (state_q == ST_DONE);
  assign depth               = cnt_q;

`ifdef RAS_UNDERFLOW_CNT_EN
  logic        underflow;
  logic [15:0] ucnt_q;

  assign underflow = commit_pop_req && !commit_push_req && (cnt_q == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ucnt_q <= '0;
    end else if (underflow && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 1'b1;
    end
  end

  assign underflow_cnt = ucnt_q;
`else
  assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_ras_commit_tracker.sv
// Directed bench for ras_commit_tracker: push/pop corner cases, restore streaming,
// backpressure, restart on flush and asynchronous reset mid-transfer.
module tb_ras_commit_tracker;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          resetn;
  logic          commit_push_req;
  logic          commit_pop_req;
  logic [AW-1:0] commit_push_data;
  logic          flush_req;
  logic          restore_valid;
  logic          restore_ready;
  logic [IW-1:0] restore_idx;
  logic [AW-1:0] restore_data;
  logic          restore_entry_valid;
  logic          restore_busy;
  logic          restore_done;
  logic [IW:0]   depth;
  logic [15:0]   underflow_cnt;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_d [N];

  ras_commit_tracker #(.ENTRIES_NUM(N), .ADDR_W(AW)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .commit_push_req     (commit_push_req),
    .commit_pop_req      (commit_pop_req),
    .commit_push_data    (commit_push_data),
    .flush_req           (flush_req),
    .restore_valid       (restore_valid),
    .restore_ready       (restore_ready),
    .restore_idx         (restore_idx),
    .restore_data        (restore_data),
    .restore_entry_valid (restore_entry_valid),
    .restore_busy        (restore_busy),
    .restore_done        (restore_done),
    .depth               (depth),
    .underflow_cnt       (underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic push, input logic pop, input logic [AW-1:0] d);
    commit_push_req  = push;
    commit_pop_req   = pop;
    commit_push_data = d;
    tick();
    commit_push_req  = 1'b0;
    commit_pop_req   = 1'b0;
    commit_push_data = '0;
  endtask

  task automatic flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic check_beat(input int k, input logic ev, input logic [AW-1:0] d);
    check($sformatf("valid_k%0d", k), 64'(restore_valid), 64'(1));
    check($sformatf("idx_k%0d", k), 64'(restore_idx), 64'(k));
    check($sformatf("entry_valid_k%0d", k), 64'(restore_entry_valid), 64'(ev));
    check($sformatf("data_k%0d", k), 64'(restore_data), 64'(d));
    check($sformatf("done_k%0d", k), 64'(restore_done), 64'(0));
  endtask

  // Streams all N beats with ready held high, then checks the done pulse.
  task automatic run_restore(input int live);
    for (int k = 0; k < N; k++) begin
      check_beat(k, (k < live), (k < live) ? exp_d[k] : '0);
      tick();
    end
    check("done_pulse", 64'(restore_done), 64'(1));
    check("busy_in_done", 64'(restore_busy), 64'(1));
    tick();
    check("done_cleared", 64'(restore_done), 64'(0));
    check("busy_idle", 64'(restore_busy), 64'(0));
  endtask

  task automatic clear_exp();
    for (int i = 0; i < N; i++) exp_d[i] = '0;
  endtask

  initial begin
    resetn           = 1'b0;
    commit_push_req  = 1'b0;
    commit_pop_req   = 1'b0;
    commit_push_data = '0;
    flush_req        = 1'b0;
    restore_ready    = 1'b1;

    // Reset state
    #12;
    check("rst_valid", 64'(restore_valid), 64'(0));
    check("rst_busy", 64'(restore_busy), 64'(0));
    check("rst_done", 64'(restore_done), 64'(0));
    check("rst_depth", 64'(depth), 64'(0));
    check("rst_idx", 64'(restore_idx), 64'(0));
    check("rst_data", 64'(restore_data), 64'(0));
    check("rst_entry_valid", 64'(restore_entry_valid), 64'(0));
    check("rst_underflow", 64'(underflow_cnt), 64'(0));
    resetn = 1'b1;
    tick();

    // Push A,B,C then restore: C,B,A, then five invalid beats; done at flush+9
    commit(1'b1, 1'b0, 32'hAAAA_0001);
    commit(1'b1, 1'b0, 32'hBBBB_0002);
    commit(1'b1, 1'b0, 32'hCCCC_0003);
    check("depth_abc", 64'(depth), 64'(3));
    clear_exp();
    exp_d[0] = 32'hCCCC_0003;
    exp_d[1] = 32'hBBBB_0002;
    exp_d[2] = 32'hAAAA_0001;
    flush();
    run_restore(3);

    // Pop back to empty, then pop on empty
    commit(1'b0, 1'b1, '0);
    commit(1'b0, 1'b1, '0);
    commit(1'b0, 1'b1, '0);
    check("depth_popped", 64'(depth), 64'(0));
    commit(1'b0, 1'b1, '0);
    check("depth_underflow", 64'(depth), 64'(0));
`ifdef RAS_UNDERFLOW_CNT_EN
    check("underflow_cnt", 64'(underflow_cnt), 64'(1));
`else
    check("underflow_cnt_tied", 64'(underflow_cnt), 64'(0));
`endif

    // Push+pop on empty leaves one live entry
    commit(1'b1, 1'b1, 32'hEEEE_0005);
    check("depth_pushpop_empty", 64'(depth), 64'(1));
    commit(1'b0, 1'b1, '0);
    check("depth_back_empty", 64'(depth), 64'(0));

    // Push 1..9 into an 8-deep stack: the oldest entry is overwritten
    for (int i = 1; i <= 9; i++) commit(1'b1, 1'b0, AW'(i));
    check("depth_full", 64'(depth), 64'(8));
    for (int k = 0; k < N; k++) exp_d[k] = AW'(9 - k);
    flush();
    run_restore(8);

    // Down to depth 2 (top 3, next 2); push Y and pop together
    for (int i = 0; i < 6; i++) commit(1'b0, 1'b1, '0);
    check("depth_two", 64'(depth), 64'(2));
    commit(1'b1, 1'b1, 32'h0000_0055);
    check("depth_pushpop", 64'(depth), 64'(2));
    clear_exp();
    exp_d[0] = 32'h0000_0055;
    exp_d[1] = 32'h0000_0002;
    flush();
    run_restore(2);

    // Backpressure at k=2, then a restart flush at k=5
    commit(1'b1, 1'b0, 32'h0000_0077);
    check("depth_three", 64'(depth), 64'(3));
    clear_exp();
    exp_d[0] = 32'h0000_0077;
    exp_d[1] = 32'h0000_0055;
    exp_d[2] = 32'h0000_0002;
    flush();
    check_beat(0, 1'b1, exp_d[0]);
    tick();
    check_beat(1, 1'b1, exp_d[1]);
    tick();
    restore_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_beat(2, 1'b1, exp_d[2]);
      tick();
    end
    restore_ready = 1'b1;
    check_beat(2, 1'b1, exp_d[2]);
    tick();
    check_beat(3, 1'b0, '0);
    tick();
    check_beat(4, 1'b0, '0);
    tick();
    check_beat(5, 1'b0, '0);
    flush();
    run_restore(3);

    // Asynchronous reset in the middle of a transfer
    flush();
    tick();
    tick();
    check("pre_rst_busy", 64'(restore_busy), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_valid", 64'(restore_valid), 64'(0));
    check("async_rst_busy", 64'(restore_busy), 64'(0));
    check("async_rst_depth", 64'(depth), 64'(0));
    tick();
    resetn = 1'b1;
    tick();
    clear_exp();
    flush();
    run_restore(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
